// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single UART_tx transmitter between NUM_REQ byte sources.
//   A round-robin arbiter picks one pending byte and latches it into tx_data.
//   It then pulses trmt and waits for tx_done. Finally it pulses done[] for
//   the requester that won.
//
// Build option:
//   UART_ARB_LOCK_EN  When defined, this adds the lock port. A previous winner
//                     that holds both req and lock is granted again without
//                     advancing the rotation.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   asynchronous active-high reset
//   req      in   NUM_REQ   request per source
//   data     in   8*NUM_REQ flattened bytes, source i at [i*8 +: 8]
//   ack      out  NUM_REQ   one-hot 1-cycle pulse, byte accepted
//   done     out  NUM_REQ   one-hot 1-cycle pulse, byte fully sent
//   lock     in   NUM_REQ   (UART_ARB_LOCK_EN only) keep grant for packets
//   trmt     out  1-cycle start pulse to UART_tx
//   tx_data  out  byte to UART_tx, stable from trmt until done
//   tx_done  in   UART_tx frame complete (level)
//   busy     out  high from grant until the done pulse
//   cur_id   out  index of the current/last granted source
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               trmt_q, trmt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic               locked_q, locked_d;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

  // Candidate k is (rr_ptr + k) mod NUM_REQ. The sum is one bit wider, so the
  // wrap is exact for non-power-of-2 NUM_REQ and never yields an id >= NUM_REQ.
  logic [ID_W:0]      cand_sum [NUM_REQ];
  logic [ID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                            ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                            : cand_sum[gi][ID_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // The lowest offset from rr_ptr wins. Scanning downward lets the last
  // assignment win.
  logic [ID_W-1:0] pick_idx;
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) pick_idx = cand_idx[k];
    end
  end

  logic lock_hit;
`ifdef UART_ARB_LOCK_EN
  assign lock_hit = req[cur_id_q] & lock[cur_id_q];
`else
  assign lock_hit = 1'b0;
`endif

  logic [ID_W-1:0] grant_idx;
  assign grant_idx = lock_hit ? cur_id_q : pick_idx;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    done_d    = '0;
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    cur_id_d  = cur_id_q;
    locked_d  = locked_q;
    case (state_q)
      S_IDLE: begin
        // tx_done is deliberately not looked at here. It may still be high
        // from the previous frame.
        if (|req) begin
          tx_data_d = data[{grant_idx, 3'b000} +: 8];
          cur_id_d  = grant_idx;
          ack_d     = id_onehot(grant_idx);
          busy_d    = 1'b1;
          locked_d  = lock_hit;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        trmt_d  = 1'b1;
        state_d = S_WAIT;
        // A locked re-grant leaves the rotation where it was, so normal
        // round-robin resumes from the same point once lock is released.
        if (!locked_q) begin
          rr_ptr_d = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);
        end
      end
      S_WAIT: begin
        // trmt_q is high only in the first WAIT cycle. tx_done is still stale
        // then, because UART_tx clears it on the edge that ends this cycle.
        if (!trmt_q && tx_done) begin
          done_d  = id_onehot(cur_id_q);
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      trmt_q    <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      cur_id_q  <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      cur_id_q  <= cur_id_d;
      locked_q  <= locked_d;
    end
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign trmt    = trmt_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;
  assign cur_id  = cur_id_q;

endmodule
